map_arbiter: RTL and testbench

Time-division scheduler for the single-port 8x8 map RAM shared by the VGA display path and the game logic. Each 4-clock pixel period has a guaranteed display slot; remaining slots serve logic reads and writes through a req/gnt handshake. Read data is returned to the correct owner. Sits in TOP between the game logic, the map RAM and the pixel/tile renderer. Exports the pixel clock-enable that the renderer uses.

---
 rtl/map_pkg.sv | 25 ++
 rtl/map_arbiter.sv | 85 ++++++++
 tb/tb_map_arbiter.sv | 233 +++++++++++++++++++++++
 3 files changed

// File: rtl/map_pkg.sv
// Shared definitions for the 8x8 map RAM: geometry, tile codes and the
// phase reserved for display fetches.
package map_pkg;

   localparam int MAP_DIM = 8;
   localparam int ADDR_W  = 6;
   localparam int TILE_W  = 4;

   localparam logic [1:0] DISP_PH = 2'd0;

   typedef enum logic [TILE_W-1:0] {
      EMPTY       = 4'h0,
      WALL        = 4'h1,
      BOX         = 4'h2,
      DEST        = 4'h3,
      BOX_ON_DEST = 4'h4,
      PLAYER      = 4'h5
   } tile_t;

   typedef enum logic {
      OWN_DISP  = 1'b0,
      OWN_LOGIC = 1'b1
   } owner_t;

endpackage

// File: rtl/map_arbiter.sv
// Time-division scheduler for the shared single-port map RAM: phase 0 is the
// display fetch slot, every other slot (and an unused phase 0) serves logic.
module map_arbiter
   import map_pkg::*;
#(
   parameter int ADDR_W = map_pkg::ADDR_W,
   parameter int TILE_W = map_pkg::TILE_W
) (
   input  logic              clk,
   input  logic              rst,
   output logic              pix_ce,
   input  logic              disp_req,
   input  logic [ADDR_W-1:0] disp_addr,
   output logic [TILE_W-1:0] disp_tile,
   output logic              disp_vld,
   input  logic              lg_req,
   input  logic              lg_we,
   input  logic [ADDR_W-1:0] lg_addr,
   input  logic [TILE_W-1:0] lg_wdata,
   output logic              lg_gnt,
   output logic [TILE_W-1:0] lg_rdata,
   output logic              lg_rvalid,
   output logic              ram_en,
   output logic              ram_we,
   output logic [ADDR_W-1:0] ram_addr,
   output logic [TILE_W-1:0] ram_wdata,
   input  logic [TILE_W-1:0] ram_rdata
);

   logic [1:0]        ph;
   logic              disp_slot_p0;
   logic              lg_slot_p0;
   logic              rd_issue_p0;
   logic              rd_pend_p1;
   owner_t            owner_p1;
   logic              disp_ret_p1;
   logic              lg_ret_p1;
   logic [TILE_W-1:0] disp_tile_q;
   logic [TILE_W-1:0] lg_rdata_q;

   // Stage p0: slot decision and RAM issue; strobes are forced low during reset
   always_comb begin
      disp_slot_p0 = (ph == DISP_PH) && disp_req;
      lg_slot_p0   = lg_req && !disp_slot_p0;
      rd_issue_p0  = disp_slot_p0 || (lg_slot_p0 && !lg_we);
   end

   assign pix_ce    = (ph == 2'd3);
   assign ram_en    = !rst && (disp_slot_p0 || lg_slot_p0);
   assign ram_we    = !rst && lg_slot_p0 && lg_we;
   assign lg_gnt    = !rst && lg_slot_p0;
   assign ram_addr  = rst          ? '0        :
                      disp_slot_p0 ? disp_addr :
                      lg_slot_p0   ? lg_addr   : '0;
   assign ram_wdata = ram_we ? lg_wdata : '0;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ph          <= DISP_PH;
         rd_pend_p1  <= 1'b0;
         owner_p1    <= OWN_DISP;
         disp_tile_q <= '0;
         lg_rdata_q  <= '0;
      end else begin
         ph         <= ph + 2'd1;
         rd_pend_p1 <= rd_issue_p0;
         if (rd_issue_p0)
            owner_p1 <= disp_slot_p0 ? OWN_DISP : OWN_LOGIC;
         if (disp_ret_p1)
            disp_tile_q <= ram_rdata;
         if (lg_ret_p1)
            lg_rdata_q <= ram_rdata;
      end
   end

   // Stage p1: route the returning word to its owner; valid coincides with data
   assign disp_ret_p1 = rd_pend_p1 && (owner_p1 == OWN_DISP);
   assign lg_ret_p1   = rd_pend_p1 && (owner_p1 == OWN_LOGIC);

   assign disp_vld  = disp_ret_p1;
   assign lg_rvalid = lg_ret_p1;
   assign disp_tile = disp_ret_p1 ? ram_rdata : disp_tile_q;
   assign lg_rdata  = lg_ret_p1   ? ram_rdata : lg_rdata_q;

endmodule

// File: tb/tb_map_arbiter.sv
// Self-checking bench for map_arbiter: directed scenarios plus random traffic
// compared against a cycle-count based reference model of the slot rules.
module tb_map_arbiter;
   import map_pkg::*;

   localparam int AW = 6;
   localparam int TW = 4;

   logic          clk = 1'b0;
   logic          rst;
   logic          pix_ce;
   logic          disp_req;
   logic [AW-1:0] disp_addr;
   logic [TW-1:0] disp_tile;
   logic          disp_vld;
   logic          lg_req;
   logic          lg_we;
   logic [AW-1:0] lg_addr;
   logic [TW-1:0] lg_wdata;
   logic          lg_gnt;
   logic [TW-1:0] lg_rdata;
   logic          lg_rvalid;
   logic          ram_en;
   logic          ram_we;
   logic [AW-1:0] ram_addr;
   logic [TW-1:0] ram_wdata;
   logic [TW-1:0] ram_rdata;

   map_arbiter #(.ADDR_W(AW), .TILE_W(TW)) dut (
      .clk       (clk),
      .rst       (rst),
      .pix_ce    (pix_ce),
      .disp_req  (disp_req),
      .disp_addr (disp_addr),
      .disp_tile (disp_tile),
      .disp_vld  (disp_vld),
      .lg_req    (lg_req),
      .lg_we     (lg_we),
      .lg_addr   (lg_addr),
      .lg_wdata  (lg_wdata),
      .lg_gnt    (lg_gnt),
      .lg_rdata  (lg_rdata),
      .lg_rvalid (lg_rvalid),
      .ram_en    (ram_en),
      .ram_we    (ram_we),
      .ram_addr  (ram_addr),
      .ram_wdata (ram_wdata),
      .ram_rdata (ram_rdata)
   );

   always #5 clk = ~clk;

   // External map RAM: one synchronous port
   logic [TW-1:0] mem      [64];
   logic [TW-1:0] init_img [64];
   logic          load;

   always @(posedge clk) begin
      if (load) begin
         for (int i = 0; i < 64; i++) mem[i] <= init_img[i];
      end else if (ram_en) begin
         if (ram_we) mem[ram_addr] <= ram_wdata;
         else        ram_rdata     <= mem[ram_addr];
      end
   end

   int            total = 0;
   int            bad   = 0;
   int            cyc;
   int            pend_kind;   // 0 none, 1 display return due, 2 logic return due
   logic [TW-1:0] pend_data;
   logic [TW-1:0] disp_m;
   logic [TW-1:0] lg_m;
   logic [TW-1:0] ref_mem [64];

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      cyc       = 0;
      pend_kind = 0;
      pend_data = '0;
      disp_m    = '0;
      lg_m      = '0;
   endtask

   task automatic check_zero(input string tag);
      chk({tag, "_pix_ce"},    32'(pix_ce),    32'd0);
      chk({tag, "_ram_en"},    32'(ram_en),    32'd0);
      chk({tag, "_ram_we"},    32'(ram_we),    32'd0);
      chk({tag, "_ram_addr"},  32'(ram_addr),  32'd0);
      chk({tag, "_ram_wdata"}, 32'(ram_wdata), 32'd0);
      chk({tag, "_lg_gnt"},    32'(lg_gnt),    32'd0);
      chk({tag, "_disp_vld"},  32'(disp_vld),  32'd0);
      chk({tag, "_lg_rvalid"}, 32'(lg_rvalid), 32'd0);
      chk({tag, "_disp_tile"}, 32'(disp_tile), 32'd0);
      chk({tag, "_lg_rdata"},  32'(lg_rdata),  32'd0);
   endtask

   // One clock: drive inputs, check at the falling edge, advance the model.
   task automatic cycle(input logic dr, input logic [AW-1:0] da, input logic lr,
                        input logic lw, input logic [AW-1:0] la, input logic [TW-1:0] ld);
      int            p;
      logic          ed, eg, een, ewe;
      logic [AW-1:0] ea;
      logic [TW-1:0] edt, elr;
      disp_req  = dr;
      disp_addr = da;
      lg_req    = lr;
      lg_we     = lw;
      lg_addr   = la;
      lg_wdata  = ld;
      #4;
      p   = cyc % 4;
      ed  = (p == 0) && dr;
      eg  = lr && !ed;
      een = ed || eg;
      ewe = eg && lw;
      ea  = ed ? da : la;
      edt = (pend_kind == 1) ? pend_data : disp_m;
      elr = (pend_kind == 2) ? pend_data : lg_m;
      chk("pix_ce",    32'(pix_ce),    32'(p == 3));
      chk("ram_en",    32'(ram_en),    32'(een));
      chk("ram_we",    32'(ram_we),    32'(ewe));
      chk("lg_gnt",    32'(lg_gnt),    32'(eg));
      if (een) chk("ram_addr",  32'(ram_addr),  32'(ea));
      if (ewe) chk("ram_wdata", 32'(ram_wdata), 32'(ld));
      chk("disp_vld",  32'(disp_vld),  32'(pend_kind == 1));
      chk("lg_rvalid", 32'(lg_rvalid), 32'(pend_kind == 2));
      chk("disp_tile", 32'(disp_tile), 32'(edt));
      chk("lg_rdata",  32'(lg_rdata),  32'(elr));
      disp_m    = edt;
      lg_m      = elr;
      pend_kind = 0;
      if (een && !ewe) begin
         pend_kind = ed ? 1 : 2;
         pend_data = ref_mem[ea];
      end
      if (ewe) ref_mem[la] = ld;
      cyc++;
      @(posedge clk);
      #1;
   endtask

   task automatic idle_to(input int p);
      while (cyc % 4 != p) cycle(1'b0, '0, 1'b0, 1'b0, '0, '0);
   endtask

   initial begin
      rst       = 1'b1;
      load      = 1'b1;
      disp_req  = 1'b0;
      disp_addr = '0;
      lg_req    = 1'b0;
      lg_we     = 1'b0;
      lg_addr   = '0;
      lg_wdata  = '0;
      for (int i = 0; i < 64; i++) begin
         init_img[i] = 4'($urandom_range(0, 15));
         ref_mem[i]  = init_img[i];
      end
      init_img[9] = 4'h2;
      ref_mem[9]  = 4'h2;
      model_reset();
      @(posedge clk);
      #1;
      load = 1'b0;

      // Requests presented while reset is held must not reach the RAM
      disp_req = 1'b1; disp_addr = 6'd9;
      lg_req = 1'b1; lg_we = 1'b1; lg_addr = 6'd7; lg_wdata = 4'hF;
      #2;
      check_zero("in_reset");
      @(posedge clk);
      #1;
      rst = 1'b0;
      model_reset();

      // Display only
      repeat (8) cycle(1'b1, 6'd9, 1'b0, 1'b0, '0, '0);
      chk("disp_tile_held", 32'(disp_tile), 32'h2);

      // Contention at phase 0, logic granted in phase 1
      idle_to(0);
      cycle(1'b1, 6'd9, 1'b1, 1'b0, 6'd5, '0);
      cycle(1'b1, 6'd9, 1'b1, 1'b0, 6'd5, '0);
      cycle(1'b0, '0, 1'b0, 1'b0, '0, '0);
      chk("contend_rdata", 32'(lg_rdata), 32'(init_img[5]));
      chk("contend_disp_tile", 32'(disp_tile), 32'h2);

      // Work-conserving write in an unused phase 0, then read back
      idle_to(0);
      cycle(1'b0, '0, 1'b1, 1'b1, 6'd63, 4'h3);
      cycle(1'b0, '0, 1'b0, 1'b0, '0, '0);
      cycle(1'b0, '0, 1'b1, 1'b0, 6'd63, '0);
      cycle(1'b0, '0, 1'b0, 1'b0, '0, '0);
      chk("readback_63", 32'(lg_rdata), 32'h3);

      // Back-to-back logic reads followed by a served display fetch
      idle_to(1);
      cycle(1'b0, '0, 1'b1, 1'b0, 6'd10, '0);
      cycle(1'b0, '0, 1'b1, 1'b0, 6'd11, '0);
      cycle(1'b0, '0, 1'b1, 1'b0, 6'd12, '0);
      cycle(1'b1, 6'd9, 1'b0, 1'b0, '0, '0);
      cycle(1'b0, '0, 1'b0, 1'b0, '0, '0);

      // Random traffic
      repeat (400) cycle(1'($urandom), 6'($urandom), 1'($urandom), 1'($urandom),
                         6'($urandom), 4'($urandom));

      // Reset lands while a logic read is pending
      idle_to(1);
      cycle(1'b0, '0, 1'b1, 1'b0, 6'd20, '0);
      rst = 1'b1;
      lg_req = 1'b1; lg_we = 1'b1; lg_addr = 6'd21; lg_wdata = 4'hA;
      #1;
      check_zero("rst_pending");
      @(posedge clk);
      #1;
      rst = 1'b0;
      model_reset();
      repeat (6) cycle(1'b0, '0, 1'b0, 1'b0, '0, '0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
